// File: rtl/paul_alu_pkg.sv
// Shared definitions for the Paul-ALU front end: arbiter state encoding,
// op_code values and the default watchdog limit.
package paul_alu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_Q = 3'd1,
      ST_LOAD_M = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/alu_op_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] onehot,
   output logic [IW-1:0]   idx,
   output logic            any
);

   int            j;
   logic [IW-1:0] jj;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = 0;
      jj     = '0;
      for (int k = 0; k < NREQ; k++) begin
         j  = (int'(ptr) + k) % NREQ;
         jj = IW'(j);
         if (!any && req[jj]) begin
            any        = 1'b1;
            onehot[jj] = 1'b1;
            idx        = jj;
         end
      end
   end

endmodule

// File: rtl/alu_op_arbiter.sv
// Round-robin front end sharing one Paul-ALU core: two-beat operand load,
// result capture, divide-by-zero rejection and a watchdog per operation.
module alu_op_arbiter #(
   parameter int         NREQ    = 2,
   parameter int         W       = 8,
   parameter int         TIMEOUT = paul_alu_pkg::TIMEOUT_DEF,
   parameter logic [1:0] OP_DIV  = paul_alu_pkg::OP_DIV
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic [NREQ-1:0]   req,
   input  logic [2*NREQ-1:0] req_op,
   input  logic [W*NREQ-1:0] req_a,
   input  logic [W*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              err,
   output logic [W-1:0]      res_lo,
   output logic [W-1:0]      res_hi,
   output logic              alu_begin_op,
   output logic [1:0]        alu_op_code,
   output logic [W-1:0]      alu_inbus,
   input  logic              alu_lo_vld,
   input  logic              alu_hi_vld,
   input  logic [W-1:0]      alu_outbus,
   input  logic              alu_end_op
);
   import paul_alu_pkg::*;

   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t            state, state_n;
   logic [1:0]        op_r, op_n;
   logic [W-1:0]      a_r, a_n, b_r, b_n;
   logic [IW-1:0]     g_r, g_n, rr, rr_n;
   logic [WD_W-1:0]   wd, wd_n;
   logic [NREQ-1:0]   gnt_n, done_n;
   logic              err_n, begin_n;
   logic [W-1:0]      res_lo_n, res_hi_n, inbus_n;
   logic [1:0]        opc_n;

   logic [1:0]        op_slot [NREQ];
   logic [W-1:0]      a_slot  [NREQ];
   logic [W-1:0]      b_slot  [NREQ];
   logic [NREQ-1:0]   pick_onehot;
   logic [IW-1:0]     pick_idx;
   logic              pick_any;

   for (genvar i = 0; i < NREQ; i++) begin : g_slot
      assign op_slot[i] = req_op[2*i +: 2];
      assign a_slot[i]  = req_a[W*i +: W];
      assign b_slot[i]  = req_b[W*i +: W];
   end

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req    (req),
      .ptr    (rr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state        <= ST_IDLE;
         op_r         <= '0;
         a_r          <= '0;
         b_r          <= '0;
         g_r          <= '0;
         rr           <= '0;
         wd           <= '0;
         gnt          <= '0;
         done         <= '0;
         err          <= 1'b0;
         res_lo       <= '0;
         res_hi       <= '0;
         alu_begin_op <= 1'b0;
         alu_op_code  <= '0;
         alu_inbus    <= '0;
      end else begin
         state        <= state_n;
         op_r         <= op_n;
         a_r          <= a_n;
         b_r          <= b_n;
         g_r          <= g_n;
         rr           <= rr_n;
         wd           <= wd_n;
         gnt          <= gnt_n;
         done         <= done_n;
         err          <= err_n;
         res_lo       <= res_lo_n;
         res_hi       <= res_hi_n;
         alu_begin_op <= begin_n;
         alu_op_code  <= opc_n;
         alu_inbus    <= inbus_n;
      end
   end

   // Next values for every registered output; done and begin_op are pulses.
   always_comb begin
      state_n  = state;
      op_n     = op_r;
      a_n      = a_r;
      b_n      = b_r;
      g_n      = g_r;
      rr_n     = rr;
      wd_n     = wd;
      gnt_n    = gnt;
      done_n   = '0;
      err_n    = err;
      res_lo_n = res_lo;
      res_hi_n = res_hi;
      begin_n  = 1'b0;
      opc_n    = alu_op_code;
      inbus_n  = alu_inbus;

      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               op_n     = op_slot[pick_idx];
               a_n      = a_slot[pick_idx];
               b_n      = b_slot[pick_idx];
               g_n      = pick_idx;
               gnt_n    = pick_onehot;
               res_lo_n = '0;
               res_hi_n = '0;
               if (op_slot[pick_idx] == OP_DIV && b_slot[pick_idx] == '0) begin
                  state_n = ST_RESP;
                  done_n  = pick_onehot;
                  err_n   = 1'b1;
               end else begin
                  state_n = ST_LOAD_Q;
                  err_n   = 1'b0;
                  begin_n = 1'b1;
                  opc_n   = op_slot[pick_idx];
                  inbus_n = a_slot[pick_idx];
               end
            end
         end
         ST_LOAD_Q: begin
            state_n = ST_LOAD_M;
            inbus_n = b_r;
         end
         ST_LOAD_M: begin
            state_n = ST_WAIT;
            inbus_n = '0;
            wd_n    = '0;
         end
         ST_WAIT: begin
            wd_n = wd + 1'b1;
            if (alu_lo_vld) res_lo_n = alu_outbus;
            if (alu_hi_vld) res_hi_n = alu_outbus;
            // end_op is tested first so it wins a tie with the watchdog.
            if (alu_end_op) begin
               state_n = ST_RESP;
               done_n  = gnt;
               err_n   = 1'b0;
            end else if (wd == WD_W'(TIMEOUT - 1)) begin
               state_n = ST_RESP;
               done_n  = gnt;
               err_n   = 1'b1;
            end
         end
         ST_RESP: begin
            state_n = ST_IDLE;
            gnt_n   = '0;
            rr_n    = (g_r == IW'(NREQ - 1)) ? '0 : g_r + 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed bench for alu_op_arbiter: vector table of single operations plus
// round-robin, timeout, collision and mid-operation reset sequences.
module tb_alu_op_arbiter;
   localparam int NREQ = 2;
   localparam int W    = 8;

   logic              clk = 1'b0;
   logic              rst_b;
   logic [NREQ-1:0]   req;
   logic [2*NREQ-1:0] req_op;
   logic [W*NREQ-1:0] req_a, req_b;
   logic [NREQ-1:0]   gnt, done;
   logic              err;
   logic [W-1:0]      res_lo, res_hi;
   logic              alu_begin_op;
   logic [1:0]        alu_op_code;
   logic [W-1:0]      alu_inbus;
   logic              alu_lo_vld, alu_hi_vld, alu_end_op;
   logic [W-1:0]      alu_outbus;

   logic              req_s [NREQ];
   logic [1:0]        op_s  [NREQ];
   logic [W-1:0]      a_s   [NREQ];
   logic [W-1:0]      b_s   [NREQ];

   assign req    = {req_s[1], req_s[0]};
   assign req_op = {op_s[1], op_s[0]};
   assign req_a  = {a_s[1], a_s[0]};
   assign req_b  = {b_s[1], b_s[0]};

   int checks   = 0;
   int failures = 0;
   int begin_cnt = 0;

   alu_op_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(64), .OP_DIV(2'b11)) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .req          (req),
      .req_op       (req_op),
      .req_a        (req_a),
      .req_b        (req_b),
      .gnt          (gnt),
      .done         (done),
      .err          (err),
      .res_lo       (res_lo),
      .res_hi       (res_hi),
      .alu_begin_op (alu_begin_op),
      .alu_op_code  (alu_op_code),
      .alu_inbus    (alu_inbus),
      .alu_lo_vld   (alu_lo_vld),
      .alu_hi_vld   (alu_hi_vld),
      .alu_outbus   (alu_outbus),
      .alu_end_op   (alu_end_op)
   );

   // clock / reset block
   always #5 clk = ~clk;

   always @(negedge clk) if (alu_begin_op) begin_cnt++;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   typedef struct {
      int         idx;
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      int         end_n;
      bit         drop;
      logic [7:0] lo;
      logic [7:0] hi;
      logic       err;
      int         wcyc;
   } vec_t;

   vec_t tv [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference ALU result {hi, lo} for the operands seen on the inbus.
   function automatic logic [15:0] alu_calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'b00:   return {8'd0, a} + {8'd0, b};
         2'b01:   return {8'd0, a} - {8'd0, b};
         2'b10:   return {8'd0, a} * {8'd0, b};
         default: return (b == 8'd0) ? 16'd0 : {a % b, a / b};
      endcase
   endfunction

   // Driver: waits for a grant, follows the operand beats, plays the ALU
   // (end_n = WAIT cycle of end_op, -1 = never) and collects the response.
   task automatic op_cycle(input int end_n, input bit scramble, input bit drop_early,
                           input bit drop_after, output int g, output int lat,
                           output int wcyc, output logic [7:0] sa, output logic [7:0] sb,
                           output logic [1:0] oc, output logic [NREQ-1:0] d,
                           output logic e, output logic [7:0] lo, output logic [7:0] hi);
      logic [15:0] res;
      bit          got;
      g = -1; lat = 0; wcyc = 0; sa = '0; sb = '0; oc = '0;
      d = '0; e = 1'b0; lo = '0; hi = '0; got = 1'b0;
      for (int t = 0; t < 8 && gnt == '0; t++) begin
         tick();
         lat++;
      end
      if (gnt == '0) begin
         checks++;
         failures++;
         $display("FAIL grant_wait: got no grant expected a grant within 8 cycles");
         return;
      end
      for (int i = 0; i < NREQ; i++) if (gnt[i]) g = i;
      if (done != '0) begin
         d = done; e = err; lo = res_lo; hi = res_hi;
      end else begin
         sa = alu_inbus;
         oc = alu_op_code;
         chk("load_q_begin", alu_begin_op, 1);
         if (scramble) begin
            a_s[g] = 8'($urandom);
            b_s[g] = 8'($urandom);
         end
         if (drop_early) req_s[g] = 1'b0;
         tick();
         chk("load_m_begin", alu_begin_op, 0);
         sb = alu_inbus;
         tick();
         chk("wait_inbus_zero", alu_inbus, 0);
         res = alu_calc(oc, sa, sb);
         for (int n = 0; n < 200 && !got; n++) begin
            if (end_n >= 0) begin
               alu_lo_vld = (n == end_n - 1);
               alu_hi_vld = (n == end_n);
               alu_end_op = (n == end_n);
            end else begin
               alu_lo_vld = (n == 10);
               alu_hi_vld = 1'b0;
               alu_end_op = 1'b0;
            end
            alu_outbus = alu_lo_vld ? res[7:0] : (alu_hi_vld ? res[15:8] : 8'hA5);
            tick();
            if (done != '0) begin
               got = 1'b1;
               wcyc = n + 1;
               d = done; e = err; lo = res_lo; hi = res_hi;
            end
         end
         alu_lo_vld = 1'b0; alu_hi_vld = 1'b0; alu_end_op = 1'b0; alu_outbus = '0;
         if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_wait: got no done expected done within 200 cycles");
         end
      end
      if (drop_after) req_s[g] = 1'b0;
      tick();
      chk("resp_gap_gnt", gnt, 0);
      chk("resp_gap_done", done, 0);
   endtask

   int          g, lat, wcyc, bc0;
   logic [7:0]  sa, sb, lo, hi;
   logic [1:0]  oc;
   logic [1:0]  d;
   logic        e, saw;
   int          rr_exp [4];

   initial begin
      tv[0] = '{0, 2'b11, 8'd20,  8'd3,  27, 0, 8'h06, 8'h02, 1'b0, 28};
      tv[1] = '{1, 2'b11, 8'd50,  8'd0,   0, 0, 8'h00, 8'h00, 1'b1,  0};
      tv[2] = '{0, 2'b10, 8'd13,  8'd25,  5, 0, 8'h45, 8'h01, 1'b0,  6};
      tv[3] = '{1, 2'b11, 8'd255, 8'd16, 20, 0, 8'h0F, 8'h0F, 1'b0, 21};
      tv[4] = '{1, 2'b10, 8'd200, 8'd200, 8, 0, 8'h40, 8'h9C, 1'b0,  9};
      tv[5] = '{0, 2'b00, 8'hF0,  8'h20,  3, 0, 8'h10, 8'h01, 1'b0,  4};
      tv[6] = '{0, 2'b10, 8'd3,   8'd4,  -1, 0, 8'h0C, 8'h00, 1'b1, 64};
      tv[7] = '{1, 2'b11, 8'd100, 8'd7,  63, 0, 8'h0E, 8'h02, 1'b0, 64};
      tv[8] = '{0, 2'b11, 8'd7,   8'd0,   0, 0, 8'h00, 8'h00, 1'b1,  0};
      tv[9] = '{1, 2'b01, 8'd5,   8'd9,   4, 1, 8'hFC, 8'hFF, 1'b0,  5};
      rr_exp = '{0, 1, 0, 1};

      for (int i = 0; i < NREQ; i++) begin
         req_s[i] = 1'b0; op_s[i] = '0; a_s[i] = '0; b_s[i] = '0;
      end
      alu_lo_vld = 1'b0; alu_hi_vld = 1'b0; alu_end_op = 1'b0; alu_outbus = '0;
      rst_b = 1'b1;
      tick();
      tick();
      rst_b = 1'b0;
      chk("reset_gnt", gnt, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_res_lo", res_lo, 0);
      chk("reset_res_hi", res_hi, 0);
      chk("reset_begin", alu_begin_op, 0);
      chk("reset_op_code", alu_op_code, 0);
      chk("reset_inbus", alu_inbus, 0);

      for (int v = 0; v < 10; v++) begin
         op_s[tv[v].idx]  = tv[v].op;
         a_s[tv[v].idx]   = tv[v].a;
         b_s[tv[v].idx]   = tv[v].b;
         req_s[tv[v].idx] = 1'b1;
         bc0 = begin_cnt;
         op_cycle(tv[v].end_n, 1'b1, tv[v].drop, 1'b1, g, lat, wcyc, sa, sb, oc, d, e, lo, hi);
         chk("vec_gnt_idx", g, tv[v].idx);
         chk("vec_gnt_latency", lat, 1);
         chk("vec_done", d, 1 << tv[v].idx);
         chk("vec_err", e, tv[v].err);
         chk("vec_res_lo", lo, tv[v].lo);
         chk("vec_res_hi", hi, tv[v].hi);
         chk("vec_wait_cycles", wcyc, tv[v].wcyc);
         if (tv[v].op == 2'b11 && tv[v].b == 8'd0) begin
            chk("div0_no_begin", begin_cnt - bc0, 0);
         end else begin
            chk("vec_inbus_a", sa, tv[v].a);
            chk("vec_inbus_b", sb, tv[v].b);
            chk("vec_op_code", oc, tv[v].op);
         end
      end

      // Round-robin from reset with both requesters held high.
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      op_s[0] = 2'b10; a_s[0] = 8'd2; b_s[0] = 8'd3;
      op_s[1] = 2'b00; a_s[1] = 8'd1; b_s[1] = 8'd1;
      req_s[0] = 1'b1; req_s[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         op_cycle(2, 1'b0, 1'b0, 1'b0, g, lat, wcyc, sa, sb, oc, d, e, lo, hi);
         chk("rr_order", g, rr_exp[k]);
         chk("rr_done", d, 1 << rr_exp[k]);
         chk("rr_res_lo", lo, (rr_exp[k] == 0) ? 8'd6 : 8'd2);
      end
      req_s[0] = 1'b0; req_s[1] = 1'b0;
      tick();

      // One grant to requester 0 so the pointer sits on requester 1.
      req_s[0] = 1'b1;
      op_cycle(2, 1'b0, 1'b0, 1'b1, g, lat, wcyc, sa, sb, oc, d, e, lo, hi);
      chk("pre_reset_gnt", g, 0);
      chk("pre_reset_lo", lo, 6);

      // Reset while requester 1's operation sits in WAIT.
      op_s[1] = 2'b11; a_s[1] = 8'd20; b_s[1] = 8'd3;
      req_s[1] = 1'b1;
      tick();
      chk("rst_mid_gnt", gnt, 2'b10);
      repeat (7) tick();
      rst_b = 1'b1;
      req_s[1] = 1'b0;
      tick();
      rst_b = 1'b0;
      chk("rst_mid_outputs", {gnt, done, err, res_lo, res_hi, alu_begin_op, alu_op_code, alu_inbus}, 0);
      saw = 1'b0;
      repeat (6) begin
         tick();
         saw = saw | (|done);
      end
      chk("rst_mid_no_done", saw, 0);
      op_s[0] = 2'b00; a_s[0] = 8'd3; b_s[0] = 8'd4;
      req_s[0] = 1'b1; req_s[1] = 1'b1;
      op_cycle(3, 1'b0, 1'b0, 1'b1, g, lat, wcyc, sa, sb, oc, d, e, lo, hi);
      chk("rst_next_gnt", g, 0);
      chk("rst_next_lo", lo, 7);
      req_s[1] = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
